decode_queue: RTL and testbench

// - Next-generation RV32I decode stage: decodes one instruction per cycle, stores decoded entries in a

---
 rtl/decode_queue_pkg.sv | 45 ++++
 rtl/decode_queue_if.sv | 53 +++++
 rtl/decode_queue_instr_field_dec.sv | 99 +++++++++
 rtl/decode_queue.sv | 146 ++++++++++++++
 tb/tb_decode_queue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Purpose : Shared definitions for the RV32I decode queue: base opcodes,
//           immediate format enum and the decoded FIFO word.
// Contents: XLEN, opcode localparams, imm_fmt_e, decoded_instr_t.
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] R_TYPE    = 7'b0110011;
    localparam logic [6:0] I_TYPE_OP = 7'b0010011;
    localparam logic [6:0] I_TYPE_LD = 7'b0000011;
    localparam logic [6:0] U_TYPE    = 7'b0110111;
    localparam logic [6:0] B_TYPE    = 7'b1100011;
    localparam logic [6:0] J_TYPE    = 7'b1101111;
    localparam logic [6:0] S_TYPE    = 7'b0100011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // One FIFO word: everything execute needs for a single instruction.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_write;
        logic [XLEN-1:0] imm_value;
        logic            alu_sub_sra;
        logic            mem_read;
        logic            mem_write;
        logic            illegal;
    } decoded_instr_t;

endpackage

// File: rtl/decode_queue_if.sv
// ---------------------------------------------------------------------------
// decode_queue_if
// Purpose : Bundles the fetch-side, execute-side, flush, writeback and
//           occupancy signals of the decode queue.
// Modports: master - the environment (fetch/execute/writeback) side
//           slave  - the decode_queue side
// Signals : flush, in_valid/in_ready/instr_in/pc_in, out_valid/out_ready,
//           head payload (*_out), wb_valid/wb_rd, count_out.
// ---------------------------------------------------------------------------
interface decode_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               instr_in;
    logic [decode_pkg::XLEN-1:0] pc_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [decode_pkg::XLEN-1:0] pc_out;
    logic [6:0]                opcode_out;
    logic [2:0]                funct3_out;
    logic [6:0]                funct7_out;
    logic [4:0]                rs1_out;
    logic [4:0]                rs2_out;
    logic [4:0]                rd_out;
    logic                      rd_write_out;
    logic [decode_pkg::XLEN-1:0] imm_value_out;
    logic                      alu_sub_sra_out;
    logic                      mem_read_out;
    logic                      mem_write_out;
    logic                      illegal_out;
    logic                      wb_valid;
    logic [4:0]                wb_rd;
    logic [CW-1:0]             count_out;

    modport master (
        output flush, in_valid, instr_in, pc_in, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, pc_out, opcode_out, funct3_out, funct7_out,
               rs1_out, rs2_out, rd_out, rd_write_out, imm_value_out,
               alu_sub_sra_out, mem_read_out, mem_write_out, illegal_out, count_out
    );

    modport slave (
        input  flush, in_valid, instr_in, pc_in, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, pc_out, opcode_out, funct3_out, funct7_out,
               rs1_out, rs2_out, rd_out, rd_write_out, imm_value_out,
               alu_sub_sra_out, mem_read_out, mem_write_out, illegal_out, count_out
    );

endinterface

// File: rtl/decode_queue_instr_field_dec.sv
// ---------------------------------------------------------------------------
// instr_field_dec
// Purpose : Purely combinational RV32I field decoder producing one FIFO word.
// Ports   : instr    in  raw 32-bit instruction
//           pc       in  pc of instr
//           dec      out decoded_instr_t (payload + pc)
//           rs1_used out instruction format reads rs1
//           rs2_used out instruction format reads rs2
// ---------------------------------------------------------------------------
module instr_field_dec
    import decode_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_instr_t  dec,
    output logic            rs1_used,
    output logic            rs2_used
);

    logic [6:0]      opcode;
    imm_fmt_e        imm_fmt;
    logic            writes_rd;
    logic            legal;
    logic [XLEN-1:0] imm;

    assign opcode = instr[6:0];

    // Classify the opcode: immediate format, register usage, legality.
    always_comb begin
        imm_fmt   = IMM_NONE;
        writes_rd = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        legal     = 1'b1;
        case (opcode)
            R_TYPE: begin
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
            end
            I_TYPE_OP, I_TYPE_LD: begin
                imm_fmt   = IMM_I;
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
            end
            U_TYPE: begin
                imm_fmt   = IMM_U;
                writes_rd = 1'b1;
            end
            B_TYPE: begin
                imm_fmt  = IMM_B;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            J_TYPE: begin
                imm_fmt   = IMM_J;
                writes_rd = 1'b1;
            end
            S_TYPE: begin
                imm_fmt  = IMM_S;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Reassemble and sign-extend the scattered immediate bits.
    always_comb begin
        case (imm_fmt)
            IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Illegal entries keep flowing but must never write state.
    always_comb begin
        dec             = '0;
        dec.pc          = pc;
        dec.opcode      = opcode;
        dec.funct3      = (opcode == 7'b0) ? 3'b0 : instr[14:12];
        dec.funct7      = instr[31:25];
        dec.rs1         = rs1_used ? instr[19:15] : 5'd0;
        dec.rs2         = rs2_used ? instr[24:20] : 5'd0;
        dec.rd          = instr[11:7];
        dec.rd_write    = writes_rd & (instr[11:7] != 5'd0);
        dec.imm_value   = imm;
        dec.alu_sub_sra = ((opcode == R_TYPE) ||
                           (opcode == I_TYPE_OP && instr[14:12] == 3'b101)) ? instr[30] : 1'b0;
        dec.mem_read    = (opcode == I_TYPE_LD);
        dec.mem_write   = (opcode == S_TYPE);
        dec.illegal     = ~legal;
    end

endmodule

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// Purpose : RV32I decode stage. Decodes one instruction per cycle into a
//           DEPTH-entry FIFO and presents the head to execute over
//           valid/ready, with flush and optional RAW/WAW scoreboard.
// Ports   : req_1  in  clock, rising edge
//           reset  in  asynchronous active-high reset
//           bus    decode_queue_if.slave (fetch, execute, flush, writeback,
//                  count_out)
// Config  : `DECODE_SCOREBOARD_EN builds NREGS pending bits that stall
//           decode on RAW/WAW hazards; otherwise wb_* is ignored.
// ---------------------------------------------------------------------------
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREGS = 32
) (
    input logic           req_1,
    input logic           reset,
    decode_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(NREGS);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    decoded_instr_t incoming;
    decoded_instr_t head;
    decoded_instr_t mem [DEPTH];
    logic           rs1_used;
    logic           rs2_used;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           stall;
    logic           push;
    logic           pop;

    instr_field_dec u_dec (
        .instr    (bus.instr_in),
        .pc       (bus.pc_in),
        .dec      (incoming),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    // Readiness looks only at registered count, so a full queue refuses a
    // push even when execute pops in the same cycle (no out_ready path).
    assign bus.in_ready  = (count < FULL_COUNT) & ~bus.flush & ~stall;
    assign push          = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid & bus.out_ready;

    // FIFO storage, pointers and occupancy; flush empties it in one edge.
    always_ff @(posedge req_1 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= incoming;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head                = mem[rd_ptr];
    assign bus.pc_out          = head.pc;
    assign bus.opcode_out      = head.opcode;
    assign bus.funct3_out      = head.funct3;
    assign bus.funct7_out      = head.funct7;
    assign bus.rs1_out         = head.rs1;
    assign bus.rs2_out         = head.rs2;
    assign bus.rd_out          = head.rd;
    assign bus.rd_write_out    = head.rd_write;
    assign bus.imm_value_out   = head.imm_value;
    assign bus.alu_sub_sra_out = head.alu_sub_sra;
    assign bus.mem_read_out    = head.mem_read;
    assign bus.mem_write_out   = head.mem_write;
    assign bus.illegal_out     = head.illegal;
    assign bus.count_out       = count;

`ifdef DECODE_SCOREBOARD_EN
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_eff;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] set_mask;

    // Hazard check uses pending bits with this cycle's writeback already
    // removed, so an instruction can issue in the same cycle as its wb.
    always_comb begin
        wb_mask = '0;
        if (bus.wb_valid) begin
            wb_mask[bus.wb_rd[RW-1:0]] = 1'b1;
        end
        pend_eff = pend & ~wb_mask;
        stall    = (rs1_used & pend_eff[incoming.rs1[RW-1:0]]) |
                   (rs2_used & pend_eff[incoming.rs2[RW-1:0]]) |
                   (incoming.rd_write & pend_eff[incoming.rd[RW-1:0]]);
    end

    // Kept separate from the stall logic: push depends on stall.
    always_comb begin
        set_mask = '0;
        if (push && incoming.rd_write) begin
            set_mask[incoming.rd[RW-1:0]] = 1'b1;
        end
    end

    // OR-ing the new set after the clear lets a same-cycle set win; x0 is
    // masked so it can never become pending.
    always_ff @(posedge req_1 or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else if (bus.flush) begin
            pend <= '0;
        end else begin
            pend <= (pend_eff | set_mask) & ~{{(NREGS-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_sb;

    assign stall     = 1'b0;
    assign unused_sb = ^{bus.wb_valid, bus.wb_rd, rs1_used, rs2_used};
`endif

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 2;

    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] SW_X2_M4   = 32'hFE20AE23;
    localparam logic [31:0] ADD_X3_X1  = 32'h001081B3;
    localparam logic [31:0] ILLEGAL_7F = 32'h0000057F;

    typedef struct {
        string          name;
        logic [31:0]    instr;
        logic [31:0]    pc;
        decoded_instr_t exp;
    } vec_t;

    logic req_1 = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [13];

    decode_queue_if #(.DEPTH(DEPTH)) bus ();

    decode_queue #(.DEPTH(DEPTH), .NREGS(32)) dut (
        .req_1 (req_1),
        .reset (reset),
        .bus   (bus)
    );

    always #5 req_1 = ~req_1;

    // Hard stop in case anything stalls unexpectedly.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic decoded_instr_t mk(input logic [31:0] pc, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic rdw,
                                          input logic [31:0] imm, input logic sub,
                                          input logic mr, input logic mw, input logic ill);
        decoded_instr_t d;
        d.pc = pc; d.opcode = op; d.funct3 = f3; d.funct7 = f7;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.rd_write = rdw;
        d.imm_value = imm; d.alu_sub_sra = sub; d.mem_read = mr;
        d.mem_write = mw; d.illegal = ill;
        return d;
    endfunction

    function automatic decoded_instr_t head_view();
        decoded_instr_t h;
        h.pc = bus.pc_out; h.opcode = bus.opcode_out; h.funct3 = bus.funct3_out;
        h.funct7 = bus.funct7_out; h.rs1 = bus.rs1_out; h.rs2 = bus.rs2_out;
        h.rd = bus.rd_out; h.rd_write = bus.rd_write_out; h.imm_value = bus.imm_value_out;
        h.alu_sub_sra = bus.alu_sub_sra_out; h.mem_read = bus.mem_read_out;
        h.mem_write = bus.mem_write_out; h.illegal = bus.illegal_out;
        return h;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic ready);
        bus.in_valid  = valid;
        bus.instr_in  = instr;
        bus.pc_in     = pc;
        bus.out_ready = ready;
    endtask

    task automatic step();
        @(posedge req_1);
        #1;
    endtask

    initial begin
        // name, instr, pc, expected {pc,op,f3,f7,rs1,rs2,rd,rdw,imm,sub,mr,mw,ill}
        vecs[0]  = '{"addi_x1_5",   ADDI_X1_5,    32'h1000, mk(32'h1000, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,  1'b1, 32'h5,        1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{"sw_x2_m4",    SW_X2_M4,     32'h1004, mk(32'h1004, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd28, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[2]  = '{"add_x3",      ADD_X3_X1,    32'h1008, mk(32'h1008, 7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd3,  1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[3]  = '{"sub_x5",      32'h407302B3, 32'h100C, mk(32'h100C, 7'h33, 3'd0, 7'h20, 5'd6, 5'd7, 5'd5,  1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0)};
        vecs[4]  = '{"srai_x4",     32'h40325213, 32'h1010, mk(32'h1010, 7'h13, 3'd5, 7'h20, 5'd4, 5'd0, 5'd4,  1'b1, 32'h403,      1'b1, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{"lw_x10",      32'h00812503, 32'h1014, mk(32'h1014, 7'h03, 3'd2, 7'h00, 5'd2, 5'd0, 5'd10, 1'b1, 32'h8,        1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[6]  = '{"lui_x7",      32'h123453B7, 32'h1018, mk(32'h1018, 7'h37, 3'd5, 7'h09, 5'd0, 5'd0, 5'd7,  1'b1, 32'h12345000, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[7]  = '{"beq_m8",      32'hFE208CE3, 32'h101C, mk(32'h101C, 7'h63, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd25, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[8]  = '{"jal_x1_16",   32'h010000EF, 32'h1020, mk(32'h1020, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,  1'b1, 32'h10,       1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{"illegal_7f",  ILLEGAL_7F,   32'h1024, mk(32'h1024, 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[10] = '{"opcode_zero", 32'h00007000, 32'h1028, mk(32'h1028, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[11] = '{"addi_x0",     32'h00100013, 32'h102C, mk(32'h102C, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  1'b0, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[12] = '{"addi_x2_m1",  32'hFFF00113, 32'h1030, mk(32'h1030, 7'h13, 3'd0, 7'h7F, 5'd0, 5'd0, 5'd2,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0)};

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = 5'd0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_count",     bus.count_out, 2'd0);
        checkOutput("reset_in_ready",  bus.in_ready,  1'b1);
        checkOutput("reset_payload",   head_view(),   '0);
        reset = 1'b0;
        step();

        // ADDI x1 with execute ready: visible one edge later, popped the next.
        applyStimulus(1'b1, ADDI_X1_5, 32'h100, 1'b1);
        #1;
        checkOutput("addi_in_ready", bus.in_ready, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("addi_out_valid", bus.out_valid,     1'b1);
        checkOutput("addi_pc",        bus.pc_out,        32'h100);
        checkOutput("addi_rd",        bus.rd_out,        5'd1);
        checkOutput("addi_imm",       bus.imm_value_out, 32'h5);
        checkOutput("addi_rd_write",  bus.rd_write_out,  1'b1);
        checkOutput("addi_rs2",       bus.rs2_out,       5'd0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd1;
        step();
        bus.wb_valid = 1'b0;
        checkOutput("addi_popped_count", bus.count_out, 2'd0);
        checkOutput("addi_popped_valid", bus.out_valid, 1'b0);

        // Decode table: one entry at a time, retired so no hazard carries over.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b0);
            step();
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
            checkOutput({vecs[i].name, "_valid"},   bus.out_valid, 1'b1);
            checkOutput({vecs[i].name, "_payload"}, head_view(),   vecs[i].exp);
            bus.out_ready = 1'b1;
            bus.wb_valid  = vecs[i].exp.rd_write;
            bus.wb_rd     = vecs[i].exp.rd;
            step();
            bus.out_ready = 1'b0;
            bus.wb_valid  = 1'b0;
            checkOutput({vecs[i].name, "_drained"}, bus.count_out, 2'd0);
        end

        // Backpressure: two accepts fill the queue, third waits, order kept.
        applyStimulus(1'b1, SW_X2_M4, 32'h200, 1'b0);
        #1;
        checkOutput("bp_ready_0", bus.in_ready, 1'b1);
        step();
        checkOutput("bp_count_1", bus.count_out, 2'd1);
        bus.pc_in = 32'h204;
        #1;
        checkOutput("bp_ready_1", bus.in_ready, 1'b1);
        step();
        bus.pc_in = 32'h208;
        #1;
        checkOutput("bp_count_2",   bus.count_out, 2'd2);
        checkOutput("bp_full_ready", bus.in_ready, 1'b0);
        checkOutput("bp_head_0",    bus.pc_out,    32'h200);
        step();
        checkOutput("bp_hold_count", bus.count_out, 2'd2);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_full_pop_ready", bus.in_ready, 1'b0);
        step();
        checkOutput("bp_pop_count", bus.count_out, 2'd1);
        checkOutput("bp_head_1",    bus.pc_out,    32'h204);
        checkOutput("bp_ready_2",   bus.in_ready,  1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("bp_pushpop_count", bus.count_out, 2'd1);
        checkOutput("bp_head_2",        bus.pc_out,    32'h208);
        step();
        bus.out_ready = 1'b0;
        checkOutput("bp_empty_count", bus.count_out, 2'd0);
        checkOutput("bp_empty_valid", bus.out_valid, 1'b0);

        // Flush a full queue while fetch offers another instruction.
        applyStimulus(1'b1, SW_X2_M4, 32'h300, 1'b0);
        step();
        bus.pc_in = 32'h304;
        step();
        checkOutput("fl_full_count", bus.count_out, 2'd2);
        bus.pc_in = 32'h308;
        bus.flush = 1'b1;
        #1;
        checkOutput("fl_in_ready", bus.in_ready, 1'b0);
        step();
        bus.flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("fl_count", bus.count_out, 2'd0);
        checkOutput("fl_valid", bus.out_valid, 1'b0);
        step();
        checkOutput("fl_valid_later", bus.out_valid, 1'b0);

        // Flush with room left: the offered push must be dropped.
        applyStimulus(1'b1, SW_X2_M4, 32'h400, 1'b0);
        step();
        bus.pc_in = 32'h404;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checkOutput("fl2_count", bus.count_out, 2'd0);
        bus.pc_in = 32'h408;
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("fl2_refill_count", bus.count_out, 2'd1);
        checkOutput("fl2_refill_head",  bus.pc_out,    32'h408);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Illegal entry queued, then reset asserted mid-cycle.
        applyStimulus(1'b1, ILLEGAL_7F, 32'h500, 1'b0);
        step();
        applyStimulus(1'b1, SW_X2_M4, 32'h504, 1'b0);
        checkOutput("ill_flag",     bus.illegal_out,   1'b1);
        checkOutput("ill_rd_write", bus.rd_write_out,  1'b0);
        checkOutput("ill_mem",      {bus.mem_read_out, bus.mem_write_out}, 2'b00);
        step();
        checkOutput("mid_count_pre", bus.count_out, 2'd2);
        applyStimulus(1'b1, SW_X2_M4, 32'h508, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_count", bus.count_out, 2'd0);
        checkOutput("mid_reset_valid", bus.out_valid, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        step();
        checkOutput("post_reset_count", bus.count_out, 2'd0);
        checkOutput("post_reset_pc",    bus.pc_out,    32'h0);

        // Dependent ADD right after ADDI x1.
        applyStimulus(1'b1, ADDI_X1_5, 32'h600, 1'b1);
        step();
        applyStimulus(1'b1, ADD_X3_X1, 32'h604, 1'b1);
        #1;
`ifdef DECODE_SCOREBOARD_EN
        checkOutput("sb_stall_0", bus.in_ready, 1'b0);
        step();
        checkOutput("sb_stall_count", bus.count_out, 2'd0);
        checkOutput("sb_stall_1",     bus.in_ready,  1'b0);
        step();
        checkOutput("sb_stall_2", bus.in_ready, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd1;
        #1;
        checkOutput("sb_wb_ready", bus.in_ready, 1'b1);
        step();
        bus.wb_valid = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("sb_add_valid", bus.out_valid, 1'b1);
        checkOutput("sb_add_pc",    bus.pc_out,    32'h604);
        checkOutput("sb_add_rd",    bus.rd_out,    5'd3);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        step();
        bus.wb_valid = 1'b0;
`else
        checkOutput("nosb_ready", bus.in_ready, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("nosb_count", bus.count_out, 2'd1);
        checkOutput("nosb_head",  bus.pc_out,    32'h604);
        step();
`endif
        bus.out_ready = 1'b0;
        checkOutput("final_empty", bus.count_out, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
